// File: rtl/lane_arbiter.sv
// Two-lane FIFO arbiter that merges lanes 0/1 onto one valid/ready mid lane tagged with the source lane.
// Optional LANE_ARB_STRICT_PRIO_EN: lane 0 always wins contention (default build is round-robin).
module lane_arbiter #(
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic       clk2f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    input  logic       ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_out,
    output logic       pause_0,
    output logic       pause_1,
    output logic       overflow_0,
    output logic       overflow_1
);

    logic [7:0]  mem0_q [DEPTH];
    logic [7:0]  mem1_q [DEPTH];
    logic [AW-1:0] wptr0_q, rptr0_q, wptr1_q, rptr1_q;
    logic [AW:0] cnt0_q, cnt1_q, cnt0_d, cnt1_d;
    logic [7:0]  data_out_q;
    logic        valid_out_q, lane_out_q;
    logic        pause0_q, pause1_q, ovf0_q, ovf1_q;
    logic        last_grant_s;

    logic        load_s, ne0_s, ne1_s;
    logic        gnt_valid_s, gnt_lane_s;
    logic        pop0_s, pop1_s, push0_s, push1_s;
    logic [7:0]  head0_s, head1_s;

    assign load_s  = !valid_out_q || ready_out;
    assign ne0_s   = (cnt0_q != {(AW+1){1'b0}});
    assign ne1_s   = (cnt1_q != {(AW+1){1'b0}});
    assign head0_s = mem0_q[rptr0_q];
    assign head1_s = mem1_q[rptr1_q];

`ifdef LANE_ARB_STRICT_PRIO_EN
    assign last_grant_s = 1'b0;
`else
    logic last_grant_q;
    assign last_grant_s = last_grant_q;

    // Round-robin memory: remembers which lane was granted most recently.
    always_ff @(posedge clk2f or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (gnt_valid_s) begin
            last_grant_q <= gnt_lane_s;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end
`endif

    // Grant selection; only considered when the output register can load.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_lane_s  = 1'b0;
        if (load_s) begin
            if (ne0_s && ne1_s) begin
                gnt_valid_s = 1'b1;
`ifdef LANE_ARB_STRICT_PRIO_EN
                gnt_lane_s  = 1'b0;
`else
                gnt_lane_s  = ~last_grant_s;
`endif
            end else if (ne0_s) begin
                gnt_valid_s = 1'b1;
                gnt_lane_s  = 1'b0;
            end else if (ne1_s) begin
                gnt_valid_s = 1'b1;
                gnt_lane_s  = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_lane_s  = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_lane_s  = 1'b0;
        end
    end

    assign pop0_s  = gnt_valid_s && !gnt_lane_s;
    assign pop1_s  = gnt_valid_s &&  gnt_lane_s;
    // A pop in the same cycle frees a slot, so a full lane can still accept a word.
    assign push0_s = valid_in_0 && ((cnt0_q < (AW+1)'(DEPTH)) || pop0_s);
    assign push1_s = valid_in_1 && ((cnt1_q < (AW+1)'(DEPTH)) || pop1_s);

    // Occupancy next-state for both lanes.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0_s && !pop0_s) begin
            cnt0_d = cnt0_q + (AW+1)'(1);
        end else if (!push0_s && pop0_s) begin
            cnt0_d = cnt0_q - (AW+1)'(1);
        end else begin
            cnt0_d = cnt0_q;
        end
        if (push1_s && !pop1_s) begin
            cnt1_d = cnt1_q + (AW+1)'(1);
        end else if (!push1_s && pop1_s) begin
            cnt1_d = cnt1_q - (AW+1)'(1);
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk2f) begin
        if (push0_s) mem0_q[wptr0_q] <= data_in_0;
        if (push1_s) mem1_q[wptr1_q] <= data_in_1;
    end

    // FIFO pointers, counts and lane status flags.
    always_ff @(posedge clk2f or negedge reset) begin
        if (!reset) begin
            wptr0_q  <= {AW{1'b0}};
            rptr0_q  <= {AW{1'b0}};
            wptr1_q  <= {AW{1'b0}};
            rptr1_q  <= {AW{1'b0}};
            cnt0_q   <= {(AW+1){1'b0}};
            cnt1_q   <= {(AW+1){1'b0}};
            pause0_q <= 1'b0;
            pause1_q <= 1'b0;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
        end else begin
            if (push0_s) wptr0_q <= wptr0_q + AW'(1);
            if (pop0_s)  rptr0_q <= rptr0_q + AW'(1);
            if (push1_s) wptr1_q <= wptr1_q + AW'(1);
            if (pop1_s)  rptr1_q <= rptr1_q + AW'(1);
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            pause0_q <= (cnt0_d >= (AW+1)'(AFULL_THRESH));
            pause1_q <= (cnt1_d >= (AW+1)'(AFULL_THRESH));
            ovf0_q   <= ovf0_q | (valid_in_0 && !push0_s);
            ovf1_q   <= ovf1_q | (valid_in_1 && !push1_s);
        end
    end

    // Output register: loads a granted word, clears valid when idle, holds on stall.
    always_ff @(posedge clk2f or negedge reset) begin
        if (!reset) begin
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            lane_out_q  <= 1'b0;
        end else if (load_s) begin
            valid_out_q <= gnt_valid_s;
            if (gnt_valid_s) begin
                data_out_q <= gnt_lane_s ? head1_s : head0_s;
                lane_out_q <= gnt_lane_s;
            end else begin
                data_out_q <= data_out_q;
                lane_out_q <= lane_out_q;
            end
        end else begin
            data_out_q  <= data_out_q;
            valid_out_q <= valid_out_q;
            lane_out_q  <= lane_out_q;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign lane_out   = lane_out_q;
    assign pause_0    = pause0_q;
    assign pause_1    = pause1_q;
    assign overflow_0 = ovf0_q;
    assign overflow_1 = ovf1_q;

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter: per-lane queues act as the scoreboard and arbitration reference.
module tb_lane_arbiter;

    localparam int DEPTH  = 4;
    localparam int THRESH = 3;

    logic       clk2f = 1'b0;
    logic       reset;
    logic [7:0] data_in_0, data_in_1;
    logic       valid_in_0, valid_in_1, ready_out;
    logic [7:0] data_out;
    logic       valid_out, lane_out, pause_0, pause_1, overflow_0, overflow_1;

    lane_arbiter #(.DEPTH(DEPTH), .AW(2), .AFULL_THRESH(THRESH)) dut (
        .clk2f(clk2f), .reset(reset),
        .data_in_0(data_in_0), .valid_in_0(valid_in_0),
        .data_in_1(data_in_1), .valid_in_1(valid_in_1),
        .ready_out(ready_out),
        .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
        .pause_0(pause_0), .pause_1(pause_1),
        .overflow_0(overflow_0), .overflow_1(overflow_1)
    );

    always #5 clk2f = ~clk2f;

    byte unsigned q0[$];
    byte unsigned q1[$];
    logic       m_lastg, m_vout, m_lane, m_p0, m_p1, m_o0, m_o1;
    logic [7:0] m_data;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_data [4];
    logic       exp_lane [4];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_lastg = 1'b1;
        m_vout  = 1'b0;
        m_lane  = 1'b0;
        m_data  = 8'h00;
        m_p0 = 1'b0; m_p1 = 1'b0; m_o0 = 1'b0; m_o1 = 1'b0;
    endtask

    // One clock: advance the reference with the current inputs, then compare after the edge.
    task automatic step();
        logic ld, g, gl;
        byte unsigned hd;
        ld = !m_vout || ready_out;
        g  = 1'b0;
        gl = 1'b0;
        hd = 8'h00;
        if (ld) begin
            if (q0.size() > 0 && q1.size() > 0) begin
                g = 1'b1;
`ifdef LANE_ARB_STRICT_PRIO_EN
                gl = 1'b0;
`else
                gl = ~m_lastg;
`endif
            end else if (q0.size() > 0) begin
                g = 1'b1; gl = 1'b0;
            end else if (q1.size() > 0) begin
                g = 1'b1; gl = 1'b1;
            end
        end
        if (g) hd = gl ? q1.pop_front() : q0.pop_front();
        if (valid_in_0) begin
            if (q0.size() < DEPTH) q0.push_back(data_in_0); else m_o0 = 1'b1;
        end
        if (valid_in_1) begin
            if (q1.size() < DEPTH) q1.push_back(data_in_1); else m_o1 = 1'b1;
        end
        if (ld) begin
            m_vout = g;
            if (g) begin
                m_data  = hd;
                m_lane  = gl;
                m_lastg = gl;
            end
        end
        m_p0 = (q0.size() >= THRESH);
        m_p1 = (q1.size() >= THRESH);
        @(posedge clk2f);
        #1;
        check("flags", {11'b0, valid_out, pause_0, pause_1, overflow_0, overflow_1},
                       {11'b0, m_vout, m_p0, m_p1, m_o0, m_o1});
        if (m_vout) check("word", {7'b0, lane_out, data_out}, {7'b0, m_lane, m_data});
    endtask

    task automatic idle();
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    initial begin
`ifdef LANE_ARB_STRICT_PRIO_EN
        exp_data[0] = 8'hA0; exp_data[1] = 8'hA1; exp_data[2] = 8'hA2; exp_data[3] = 8'hA3;
        exp_lane[0] = 1'b0;  exp_lane[1] = 1'b0;  exp_lane[2] = 1'b0;  exp_lane[3] = 1'b0;
`else
        exp_data[0] = 8'hA0; exp_data[1] = 8'hB0; exp_data[2] = 8'hA1; exp_data[3] = 8'hB1;
        exp_lane[0] = 1'b0;  exp_lane[1] = 1'b1;  exp_lane[2] = 1'b0;  exp_lane[3] = 1'b1;
`endif
        reset = 1'b0;
        idle();
        data_in_0 = 8'h00;
        data_in_1 = 8'h00;
        ready_out = 1'b1;
        model_reset();

        // Reset held with toggling inputs.
        for (int i = 0; i < 4; i++) begin
            valid_in_0 = i[0];
            valid_in_1 = ~i[0];
            data_in_0  = 8'($urandom_range(0, 255));
            data_in_1  = 8'($urandom_range(0, 255));
            ready_out  = i[1];
            @(posedge clk2f);
            #1;
            check("reset", {3'b0, data_out, valid_out, lane_out, pause_0, pause_1, overflow_0, overflow_1}, 16'h0000);
        end
        idle();
        ready_out = 1'b1;
        reset = 1'b1;

        // Both lanes every cycle: alternation (or lane 0 only under strict priority).
        for (int i = 0; i < 10; i++) begin
            valid_in_0 = (i < 4);
            valid_in_1 = (i < 4);
            data_in_0  = 8'hA0 + 8'(i);
            data_in_1  = 8'hB0 + 8'(i);
            step();
            if (i >= 1 && i <= 4)
                check("alt", {7'b0, lane_out, data_out}, {7'b0, exp_lane[i-1], exp_data[i-1]});
        end

        // Stall while lane 0 keeps pushing.
        valid_in_0 = 1'b1; data_in_0 = 8'h10; ready_out = 1'b1;
        step();
        ready_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_in_0 = 8'h11 + 8'(i);
            step();
            if (i == 3) check("no_ovf_yet", {15'b0, overflow_0}, 16'h0000);
            if (i == 4) check("ovf_5th", {15'b0, overflow_0}, 16'h0001);
        end
        check("stall_hold", {6'b0, valid_out, lane_out, data_out}, {6'b0, 1'b1, 1'b0, 8'h10});
        check("stall_pause", {15'b0, pause_0}, 16'h0001);
        idle();
        ready_out = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Reset with words queued on both lanes and an output word held.
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in_0 = 1'b1; data_in_0 = 8'hC0 + 8'(i);
            valid_in_1 = 1'b1; data_in_1 = 8'hD0 + 8'(i);
            step();
        end
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("midrst", {3'b0, data_out, valid_out, lane_out, pause_0, pause_1, overflow_0, overflow_1}, 16'h0000);
        model_reset();
        @(posedge clk2f);
        #1;
        reset = 1'b1;
        ready_out = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Lane 0 full, push on the pop cycle.
        valid_in_0 = 1'b1; data_in_0 = 8'h20;
        step();
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in_0 = 8'h21 + 8'(i);
            step();
        end
        check("full_pause", {15'b0, pause_0}, 16'h0001);
        ready_out = 1'b1;
        data_in_0 = 8'h77;
        step();
        check("fullpp_ovf", {15'b0, overflow_0}, 16'h0000);
        idle();
        for (int i = 0; i < 6; i++) step();

        // Single word on lane 1.
        valid_in_1 = 1'b1; data_in_1 = 8'h55;
        step();
        idle();
        step();
        check("single", {6'b0, valid_out, lane_out, data_out}, {6'b0, 1'b1, 1'b1, 8'h55});
        step();
        check("single_end", {15'b0, valid_out}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
